// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch front-end bus: imem req/ack, redirect and decode valid/ready
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, cond, op, funct, rd,
    input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );

  // Memory / execute / decode side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, cond, op, funct, rd,
    output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch: PC, imem req/ack, prefetch FIFO, redirect flush
module instr_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  instr_fetch_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {FETCH, STALL, DROP} state_t;

  state_t          state_q;
  logic [31:0]     fetch_pc_q;
  logic [31:0]     target_q;
  logic            req_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [31:0]     fifo_instr_q [DEPTH];
  logic [31:0]     fifo_pc_q    [DEPTH];
  logic            not_empty;
  logic            push;
  logic            pop;
  logic [31:0]     head_instr;
  logic [31:0]     redirect_tgt;

  assign not_empty    = (count_q != '0);
  assign redirect_tgt = bus.redirect_pc & ~32'd3;
  // Only words acked in FETCH are kept; a redirect discards the same-cycle word
  assign push = (state_q == FETCH) && req_q && bus.imem_ack && !bus.redirect;
  // A pop coinciding with a redirect is meaningless because the FIFO is flushed anyway
  assign pop  = not_empty && bus.instr_ready && !bus.redirect;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_d = count_q;
    if (push) count_d = count_d + CW'(1);
    if (pop)  count_d = count_d - CW'(1);
  end

  // Fetch FSM, PC, request and FIFO pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
      req_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (bus.redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      if (req_q && !bus.imem_ack) begin
        // Outstanding request cannot be withdrawn: wait for its ack, then restart
        state_q  <= DROP;
        target_q <= redirect_tgt;
      end else begin
        state_q    <= FETCH;
        fetch_pc_q <= redirect_tgt;
        req_q      <= 1'b1;
      end
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case (state_q)
        FETCH: begin
          if (push) fetch_pc_q <= fetch_pc_q + 32'd4;
          req_q   <= (count_d < CW'(DEPTH));
          state_q <= (count_d < CW'(DEPTH)) ? FETCH : STALL;
        end
        STALL: begin
          if (pop) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            state_q    <= FETCH;
            fetch_pc_q <= target_q;
            req_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= FETCH;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Prefetch storage; contents are don't-care until written, outputs are masked when empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  assign head_instr      = not_empty ? fifo_instr_q[rd_ptr_q] : '0;
  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = not_empty;
  assign bus.instr       = head_instr;
  assign bus.instr_pc    = not_empty ? fifo_pc_q[rd_ptr_q] : '0;
  assign bus.cond        = head_instr[31:28];
  assign bus.op          = head_instr[27:26];
  assign bus.funct       = head_instr[25:20];
  assign bus.rd          = head_instr[15:12];
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch with queue-based reference model
module tb_instr_fetch;
  localparam int DEPTH = 2;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  instr_fetch_if bus ();
  instr_fetch_if wb ();

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (wb)
  );

  assign wb.imem_ack    = 1'b1;
  assign wb.imem_rdata  = wb.imem_addr ^ 32'h5A5A_5A5A;
  assign wb.redirect    = 1'b0;
  assign wb.redirect_pc = 32'h0;
  assign wb.instr_ready = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of delivered words plus the address of the next fetch
  logic [31:0] m_q_instr [$];
  logic [31:0] m_q_pc    [$];
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_drop;
  logic [31:0] m_target;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q_instr.delete();
    m_q_pc.delete();
    m_req    = 1'b0;
    m_addr   = 32'h0;
    m_drop   = 1'b0;
    m_target = 32'h0;
  endtask

  task automatic compare_all();
    logic [31:0] ei;
    logic [31:0] ep;
    bit          v;
    v  = (m_q_instr.size() > 0);
    ei = v ? m_q_instr[0] : 32'h0;
    ep = v ? m_q_pc[0]    : 32'h0;
    check("imem_req", bus.imem_req, m_req);
    if (m_req) check("imem_addr", bus.imem_addr, m_addr);
    check("instr_valid", bus.instr_valid, v);
    check("instr", bus.instr, ei);
    check("instr_pc", bus.instr_pc, ep);
    check("cond", bus.cond, {28'h0, ei[31:28]});
    check("op", bus.op, {30'h0, ei[27:26]});
    check("funct", bus.funct, {26'h0, ei[25:20]});
    check("rd", bus.rd, {28'h0, ei[15:12]});
  endtask

  // One clock: compare at negedge, drive inputs, then advance the model across the coming edge
  task automatic cycle(input bit ack, input bit rdy, input bit redir, input logic [31:0] rpc,
                       input logic [31:0] rdata);
    bit a;
    bit v;
    @(negedge clk);
    compare_all();
    a = ack && m_req;
    v = (m_q_instr.size() > 0);
    bus.imem_ack    = a;
    bus.imem_rdata  = rdata;
    bus.instr_ready = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    if (redir) begin
      m_q_instr.delete();
      m_q_pc.delete();
      if (m_req && !a) begin
        m_drop   = 1'b1;
        m_target = rpc & ~32'd3;
      end else begin
        m_drop = 1'b0;
        m_addr = rpc & ~32'd3;
        m_req  = 1'b1;
      end
    end else if (m_drop) begin
      if (a) begin
        m_drop = 1'b0;
        m_addr = m_target;
        m_req  = 1'b1;
      end
    end else begin
      if (v && rdy) begin
        void'(m_q_instr.pop_front());
        void'(m_q_pc.pop_front());
      end
      if (a) begin
        m_q_instr.push_back(rdata);
        m_q_pc.push_back(m_addr);
        m_addr = m_addr + 32'd4;
      end
      m_req = (m_q_instr.size() < DEPTH);
    end
  endtask

  task automatic drive_idle();
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    drive_idle();
    model_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", bus.imem_req, 32'h0);
    check("rst_valid", bus.instr_valid, 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_pc", bus.instr_pc, 32'h0);
    #1 reset = 1'b1;

    // Streaming: ack tied high, decode always ready
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, $urandom);

    // Backpressure: fill the FIFO, request must stop, then drain
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, $urandom);
    @(posedge clk); #1;
    check("full_req_low", bus.imem_req, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, $urandom);

    // Redirect with FIFO full and no outstanding request
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, $urandom);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0103, 32'h0);
    @(posedge clk); #1;
    check("redir_valid", bus.instr_valid, 32'h0);
    check("redir_req", bus.imem_req, 32'h1);
    check("redir_addr", bus.imem_addr, 32'h0000_0100);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, $urandom);

    // Redirect during a slow request: old address held until ack, data dropped
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("drop_valid", bus.instr_valid, 32'h0);
    check("drop_addr", bus.imem_addr, 32'h0000_0200);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, $urandom);

    // Randomized traffic in blocks of differing ack/ready/redirect rates
    for (int blk = 0; blk < 8; blk++) begin
      int p_ack;
      int p_rdy;
      int p_red;
      p_ack = $urandom_range(20, 100);
      p_rdy = $urandom_range(0, 100);
      p_red = $urandom_range(0, 8);
      for (int i = 0; i < 60; i++)
        cycle($urandom_range(0, 99) < p_ack, $urandom_range(0, 99) < p_rdy,
              $urandom_range(0, 99) < p_red, $urandom, $urandom);
    end

    // Async reset in the middle of a drop
    for (int i = 0; i < 10; i++) begin
      if (m_req) break;
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    end
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_req", bus.imem_req, 32'h0);
    check("async_valid", bus.instr_valid, 32'h0);
    check("async_instr", bus.instr, 32'h0);
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Restart at RESET_PC, and the wrap instance walks through the 32-bit boundary
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_wrap;
      exp_wrap = 32'hFFFF_FFF8 + 32'(4 * i);
      cycle(1'b1, 1'b1, 1'b0, 32'h0, $urandom);
      @(posedge clk); #1;
      check("wrap_addr", wb.imem_addr, exp_wrap);
      if (i == 0) check("restart_addr", bus.imem_addr, 32'h0);
    end
    check("wrap_pc", wb.instr_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
